// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: store-size codes,
// sequencer states and MMIO register offsets.
package dmem_pkg;

    localparam logic [1:0] STORE_W    = 2'b00;
    localparam logic [1:0] STORE_B    = 2'b01;
    localparam logic [1:0] STORE_H    = 2'b10;
    localparam logic [1:0] STORE_RSVD = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_STCNT  = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Store lane steering: turns store size and the low address bits into a
// byte-lane enable, lane-replicated write data and a misalignment flag.
// The reserved size code enables no lanes; the top flags it as an error.
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]  store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    // Replicating the narrow data across lanes lets the byte enable alone pick the target lane
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (store_i)
            STORE_W: begin
                be_o       = 4'b1111;
                misalign_o = (addr_lo_i != 2'b00);
            end
            STORE_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            STORE_H: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte/halfword store lanes, a
// combinational right-justified read path, a post-reset clear sequencer
// and a sticky access-error record.
// Optional MMIO counter/status window compiled in with DATA_MEM_MMIO_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
`ifdef DATA_MEM_MMIO_EN
    ,
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [1:0]  Store,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic [31:0] ErrAddr
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    state_e         state_q;
    logic [AW-1:0]  idx_q;
    logic           ready_q;
    logic           err_q, err_d;
    logic [31:0]    erraddr_q, erraddr_d;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           run;
    logic           ram_hit;
    logic [AW-1:0]  widx;
    logic [3:0]     be;
    logic [31:0]    wdata_pos;
    logic           misalign;
    logic           mmio_hit;
    logic           mmio_bad;
    logic           status_wr;
    logic           st_err;
    logic           ram_we;
    logic [31:0]    rd_word;

    assign run     = (state_q == RUN);
    assign ram_hit = (Mem_WrAddr < RAM_BYTES);
    assign widx    = Mem_WrAddr[AW+1:2];

    dmem_lane_ctrl u_lane (
        .store_i    (Store),
        .addr_lo_i  (Mem_WrAddr[1:0]),
        .wdata_i    (Mem_WrData),
        .be_o       (be),
        .wdata_o    (wdata_pos),
        .misalign_o (misalign)
    );

`ifdef DATA_MEM_MMIO_EN
    logic [31:0] cyc_q;
    logic [31:0] stcnt_q;
    logic [3:0]  mmio_word;

    // RAM decode wins over the window should the two ever overlap
    assign mmio_hit  = !ram_hit && (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);
    assign mmio_word = {Mem_WrAddr[3:2], 2'b00};
    assign mmio_bad  = mmio_hit && (mmio_word != OFF_CYCLE) && (mmio_word != OFF_STCNT)
                       && (mmio_word != OFF_STATUS);
    assign status_wr = run && MemWrite && mmio_hit && (Store == STORE_W) && !misalign
                       && (mmio_word == OFF_STATUS);
`else
    assign mmio_hit  = 1'b0;
    assign mmio_bad  = 1'b0;
    assign status_wr = 1'b0;
`endif

    // Stores are only judged in RUN; anything arriving during the clear is dropped silently
    assign st_err = run && MemWrite && ((Store == STORE_RSVD) || misalign
                    || (!ram_hit && !mmio_hit) || mmio_bad);
    assign ram_we = run && MemWrite && ram_hit && !st_err;

    // Clear sequencer: walks every word once after reset, then holds in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            idx_q <= idx_q + AW'(1);
            if (idx_q == AW'(DEPTH_WORDS - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Error record: first failing address is kept until a reset or status write
    always_comb begin
        err_d     = err_q;
        erraddr_d = erraddr_q;
        if (status_wr) begin
            err_d     = 1'b0;
            erraddr_d = '0;
        end else if (st_err) begin
            err_d = 1'b1;
            if (!err_q) erraddr_d = Mem_WrAddr;
        end
    end

    // Error record registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

`ifdef DATA_MEM_MMIO_EN
    // Window counters: cycles spent in RUN and successful RAM stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q   <= '0;
            stcnt_q <= '0;
        end else begin
            if (run)    cyc_q   <= cyc_q + 32'd1;
            if (ram_we) stcnt_q <= stcnt_q + 32'd1;
        end
    end
`endif

    // RAM array: the sequencer owns the write port while clearing
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[idx_q] <= '0;
        end else if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[widx][8*l +: 8] <= wdata_pos[8*l +: 8];
            end
        end
    end

    // Read mux: zero while clearing and on misses, then right-justify by byte offset
    always_comb begin
        rd_word = '0;
        if (run) begin
            if (ram_hit) begin
                rd_word = mem[widx];
            end
`ifdef DATA_MEM_MMIO_EN
            else if (mmio_hit) begin
                case (mmio_word)
                    OFF_CYCLE:  rd_word = cyc_q;
                    OFF_STCNT:  rd_word = stcnt_q;
                    OFF_STATUS: rd_word = {31'b0, err_q};
                    default:    rd_word = '0;
                endcase
            end
`endif
        end
    end

    assign ReadData = rd_word >> {Mem_WrAddr[1:0], 3'b000};
    assign MemReady = ready_q;
    assign MemErr   = err_q;
    assign ErrAddr  = erraddr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: clear timing, a fixed vector
// table for the lane/error rules, hand sequences for reset/MMIO corners and
// randomized traffic against a byte-array reference model.
module tb_data_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] MMIO  = 32'h0200_0000;
    localparam logic [1:0]  SW = 2'b00, SB = 2'b01, SH = 2'b10, SR = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [1:0]  Store = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
    logic [31:0] ErrAddr;

    data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Store      (Store),
        .Mem_WrAddr (addr),
        .Mem_WrData (wdata),
        .ReadData   (ReadData),
        .MemReady   (MemReady),
        .MemErr     (MemErr),
        .ErrAddr    (ErrAddr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: memory as a flat byte array
    logic [7:0]  mb [4*DEPTH];
    bit          m_err;
    logic [31:0] m_eaddr;
    int          m_stcnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
        m_err = 0; m_eaddr = '0; m_stcnt = 0;
    endtask

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r = '0;
        if (a < 4*DEPTH) begin
            for (int k = 0; k < 4; k++)
                if (int'(a[1:0]) + k < 4) r[8*k +: 8] = mb[int'(a) + k];
        end
        return r;
    endfunction

    task automatic model_apply(bit we, logic [1:0] st, logic [31:0] a, logic [31:0] d);
        int sz;
        bit bad;
        if (!we) return;
        sz  = (st == SW) ? 4 : (st == SB) ? 1 : (st == SH) ? 2 : 0;
        bad = (sz == 0) ? 1'b1 : ((a % sz) != 0);
        if (!bad && a >= 4*DEPTH) begin
`ifdef DATA_MEM_MMIO_EN
            if (a >= MMIO && a < MMIO + 16) begin
                if (a >= MMIO + 12) bad = 1;
                else if (a == MMIO + 8 && sz == 4) begin m_err = 0; m_eaddr = '0; end
                if (!bad) return;
            end else bad = 1;
`else
            bad = 1;
`endif
        end
        if (bad) begin
            if (!m_err) m_eaddr = a;
            m_err = 1;
        end else begin
            for (int k = 0; k < sz; k++) mb[int'(a) + k] = d[8*k +: 8];
            m_stcnt++;
        end
    endtask

    // assert reset for one cycle, checking reset values while it is held
    task automatic do_reset();
        @(negedge clk);
        reset = 1; MemWrite = 0; addr = '0;
        model_reset();
        @(negedge clk);
        chk("rst_ready", {31'b0, MemReady}, 32'd0);
        chk("rst_err",   {31'b0, MemErr},   32'd0);
        chk("rst_eaddr", ErrAddr, 32'd0);
        reset = 0;
    endtask

    // count cycles until ready, probing reads and a dropped store mid-clear
    task automatic wait_clear();
        int cyc = 0;
        while (!MemReady && cyc < 500) begin
            if (cyc == 10) begin
                addr = 32'h0;  #1 chk("clr_rd_0",  ReadData, 32'd0);
                addr = 32'hFC; #1 chk("clr_rd_fc", ReadData, 32'd0);
            end
            if (cyc == 20) begin
                MemWrite = 1; Store = SW; addr = 32'h40; wdata = 32'hFFFF_FFFF;
            end else MemWrite = 0;
            @(posedge clk); #1;
            cyc++;
        end
        MemWrite = 0;
        chk("clear_cycles", cyc, DEPTH);
        chk("clr_no_err", {31'b0, MemErr}, 32'd0);
        addr = 32'h40; #1 chk("clr_store_dropped", ReadData, 32'd0);
        @(negedge clk);
    endtask

    // one op from a negedge: check old read, edge, check new read and error record
    task automatic do_op(bit we, logic [1:0] st, logic [31:0] a, logic [31:0] d);
        MemWrite = we; Store = st; addr = a; wdata = d;
        #1 chk("rd_old", ReadData, model_read(a));
        @(posedge clk);
        model_apply(we, st, a, d);
        #1 MemWrite = 0;
        #1 chk("rd_new", ReadData, model_read(a));
        chk("err", {31'b0, MemErr}, {31'b0, m_err});
        chk("eaddr", ErrAddr, m_eaddr);
        @(negedge clk);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd_a;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [31:0] exp_ea;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1, SW, 32'h10,  32'hDEAD_BEEF, 32'h10,  32'hDEAD_BEEF, 0, 32'h0};
        vt[1]  = '{1, SB, 32'h12,  32'h0000_0055, 32'h10,  32'hDE55_BEEF, 0, 32'h0};
        vt[2]  = '{0, SW, 32'h12,  32'h0,         32'h12,  32'h0000_DE55, 0, 32'h0};
        vt[3]  = '{1, SH, 32'h20,  32'h9999_ABCD, 32'h20,  32'h0000_ABCD, 0, 32'h0};
        vt[4]  = '{1, SH, 32'h22,  32'h0000_1234, 32'h20,  32'h1234_ABCD, 0, 32'h0};
        vt[5]  = '{1, SH, 32'h21,  32'h0000_FFFF, 32'h20,  32'h1234_ABCD, 1, 32'h21};
        vt[6]  = '{1, SW, 32'h100, 32'h1111_1111, 32'h100, 32'h0,         1, 32'h21};
        vt[7]  = '{1, SW, 32'h32,  32'h2222_2222, 32'h30,  32'h0,         1, 32'h21};
        vt[8]  = '{1, SR, 32'h40,  32'h3333_3333, 32'h40,  32'h0,         1, 32'h21};
        vt[9]  = '{1, SB, 32'hFF,  32'h0000_00AA, 32'hFC,  32'hAA00_0000, 1, 32'h21};
        vt[10] = '{0, SW, 32'hFF,  32'h0,         32'hFF,  32'h0000_00AA, 1, 32'h21};
        vt[11] = '{1, SB, 32'h13,  32'h0000_0077, 32'h10,  32'h7755_BEEF, 1, 32'h21};

        // power-on clear
        do_reset();
        wait_clear();

        // fixed vectors
        for (int i = 0; i < 12; i++) begin
            MemWrite = vt[i].we; Store = vt[i].st; addr = vt[i].a; wdata = vt[i].d;
            @(posedge clk);
            model_apply(vt[i].we, vt[i].st, vt[i].a, vt[i].d);
            #1 MemWrite = 0; addr = vt[i].rd_a;
            #1 chk($sformatf("vec%0d_rd", i), ReadData, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, MemErr}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_ea", i), ErrAddr, vt[i].exp_ea);
            @(negedge clk);
        end

        // reset 30 cycles into a clear: sequence must restart from index 0
        do_reset();
        repeat (30) @(posedge clk);
        #1 chk("midclr_ready", {31'b0, MemReady}, 32'd0);
        do_reset();
        wait_clear();
        addr = 32'h10; #1 chk("midclr_wiped", ReadData, 32'd0);
        addr = 32'hFC; #1 chk("midclr_wiped_fc", ReadData, 32'd0);
        @(negedge clk);

        // store latency: old word before the edge, new word after
        do_op(1, SW, 32'h10, 32'hCAFE_F00D);
        do_op(1, SH, 32'h12, 32'h0000_BEAD);

`ifdef DATA_MEM_MMIO_EN
        do_reset();
        wait_clear();
        do_op(1, SW, 32'h0, 32'h1);
        do_op(1, SB, 32'h5, 32'h2);
        do_op(1, SH, 32'h8, 32'h3);
        addr = MMIO + 4; #1 chk("mmio_stcnt3", ReadData, 32'd3);
        @(negedge clk);
        do_op(1, SH, 32'h21, 32'h0);
        addr = MMIO + 8; #1 chk("mmio_status_set", ReadData, 32'd1);
        @(negedge clk);
        do_op(1, SW, MMIO + 8, 32'h1234_5678);
        addr = MMIO + 8; #1 chk("mmio_status_clr", ReadData, 32'd0);
        chk("mmio_err_clr", {31'b0, MemErr}, 32'd0);
        chk("mmio_ea_clr", ErrAddr, 32'd0);
        @(negedge clk);
        do_op(1, SW, MMIO + 12, 32'h0);
`else
        do_op(1, SW, MMIO, 32'h5555_5555);
        chk("nommio_err", {31'b0, MemErr}, 32'd1);
        addr = MMIO; #1 chk("nommio_rd", ReadData, 32'd0);
        @(negedge clk);
`endif

        // randomized traffic against the model, with a reset partway through
        do_reset();
        wait_clear();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            if (n == 200) begin
                do_reset();
                wait_clear();
            end
            if ($urandom_range(0, 4) != 0) ra = $urandom_range(0, 4*DEPTH - 1);
            else ra = $urandom_range(4*DEPTH, 4*DEPTH + 32'h400);
            do_op($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ra, $urandom);
        end
`ifdef DATA_MEM_MMIO_EN
        addr = MMIO + 4; #1 chk("rand_stcnt", ReadData, m_stcnt);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle RISC-V CPU. It sits on the CPU's data port, on the far side of the Mem_WrAddr / Mem_WrData / ReadData interface.
- Provides a word-organised RAM with byte and halfword store lanes, plus a combinational right-justified read path.
- Runs a post-reset RAM-clear sequencer and keeps a sticky access-error record.
- Optionally exposes a small MMIO counter window.

## Interface
Parameters:
- DEPTH_WORDS, 64: RAM size in 32-bit words; power of two, 16..4096.
- MMIO_BASE, 32'h0200_0000: base of the MMIO window (compiled in only with the macro below).

Ports (clock and reset first; reset is asynchronous and active-high):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- MemWrite  in  1  store strobe for the current cycle.
- Store  in  2  store size: 00 word, 01 byte, 10 halfword, 11 reserved.
- Mem_WrAddr  in  32  byte address for loads and stores.
- Mem_WrData  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- ReadData  out  32  addressed word shifted right by 8*Mem_WrAddr[1:0]; combinational.
- MemReady  out  1  high in RUN state; low while clearing.
- MemErr  out  1  sticky access-error flag.
- ErrAddr  out  32  address of the first error since the last clear.

## Operation
State machine:
- CLEAR: index 0..DEPTH_WORDS-1 advances one per cycle, writing zero to each word.
  - When the index reaches DEPTH_WORDS-1, the next state is RUN.
- RUN: normal service.

Address decode:
- RAM hit when Mem_WrAddr < 4*DEPTH_WORDS.
- Word index = Mem_WrAddr[log2(DEPTH_WORDS)+1:2].

Stores (RUN, MemWrite=1, RAM hit):
- Byte store: lane Mem_WrAddr[1:0].
- Halfword store: lanes {addr[1],0} and {addr[1],1}.
- Word store: all four lanes.
- Unwritten lanes are preserved.

Errors. Any of the following suppresses the write:
- halfword store with addr[0]=1
- word store with addr[1:0]≠0
- Store=11 with MemWrite=1
- RAM miss that is also not an MMIO hit

On error:
- MemErr is set; it is sticky.
- ErrAddr captures the address only if MemErr was previously 0.
- Loads never raise errors.

Reads:
- RAM miss returns 0.
- In CLEAR, ReadData is 0 and all stores are ignored with no error.

## Timing
- Reset values: state=CLEAR, clear index=0, MemReady=0, MemErr=0, ErrAddr=0, MMIO counters=0.
- The clear takes exactly DEPTH_WORDS cycles after reset deassertion. MemReady rises on the edge that completes the last clear write.
- Store latency: a store is visible on ReadData in the cycle after its edge. The read in the same cycle returns old data.
- Reset asserted mid-clear or mid-run: the block returns to CLEAR at index 0 immediately and the whole clear sequence repeats.
- MemErr is cleared only by reset, or by an MMIO write when MMIO is enabled.

## Configuration
DATA_MEM_MMIO_EN.

Defined: word-aligned window at MMIO_BASE.
- +0: cycle counter, read-only. Free-running in RUN, wraps at 2^32.
- +4: store counter, read-only. Increments on each successful RAM store, wraps.
- +8: status. Read returns {31'b0, MemErr}. A word write of any value clears MemErr and ErrAddr; that write is not itself an error.
- Other window offsets are errors on store and read 0.
- MMIO stores in CLEAR are ignored.

Undefined:
- No window; the whole address space outside RAM is a miss.
- Counters are absent; MemErr is cleared only by reset.

## Structure
Shared package (dmem_pkg):
- store-size codes STORE_W, STORE_B, STORE_H, STORE_RSVD
- state enum CLEAR/RUN
- MMIO offsets OFF_CYCLE=0, OFF_STCNT=4, OFF_STATUS=8

One sub-module, dmem_lane_ctrl (combinational): from Store and addr[1:0], produces the 4-bit lane enable, lane-positioned write data and the misalignment flag.

## Test plan
- Reset, then count cycles → MemReady low for exactly DEPTH_WORDS (64) cycles. Reading 0x0 and 0xFC during CLEAR returns 0.
- Word-store 0xDEADBEEF to 0x10, then byte-store 0x55 to 0x12 → reading 0x10 returns 0xDE55BEEF; reading 0x12 returns 0x0000DE55.
- Halfword store to 0x21 → no write occurs, MemErr=1, ErrAddr=0x21. A later word store to 0x100 (miss) leaves ErrAddr=0x21.
- Assert reset mid-clear at index 30 → index restarts at 0. Previously stored data reads 0 after the new clear.
- DATA_MEM_MMIO_EN: three successful stores → reading MMIO_BASE+4 returns 3. After the error above, a word write to MMIO_BASE+8 clears MemErr, and reading MMIO_BASE+8 returns 0.
- Without DATA_MEM_MMIO_EN: a store to MMIO_BASE sets MemErr, and reading MMIO_BASE returns 0.
